tqvp_gpio_irq: RTL and testbench

//  TinyQV peripheral: parametrised successor of the single-register example block. Provides an output

---
 rtl/tqvp_gpio_irq_pkg.sv | 38 +++
 rtl/tqvp_input_filter.sv | 49 ++++
 rtl/tqvp_gpio_irq.sv | 121 ++++++++++++
 tb/tb_tqvp_gpio_irq.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tqvp_gpio_irq_pkg.sv
// Shared register map, edge-mode encodings and bus write-size helpers for the
// TinyQV GPIO/interrupt peripheral.
package tqvp_gpio_irq_pkg;

  localparam logic [5:0] ADDR_OUT      = 6'h00;
  localparam logic [5:0] ADDR_IN       = 6'h04;
  localparam logic [5:0] ADDR_EDGE_CFG = 6'h08;
  localparam logic [5:0] ADDR_STATUS   = 6'h0C;
  localparam logic [5:0] ADDR_ENABLE   = 6'h10;
  localparam logic [5:0] ADDR_COUNT    = 6'h14;
  localparam logic [5:0] ADDR_CMP      = 6'h18;
  localparam logic [5:0] ADDR_CTRL     = 6'h1C;

  localparam int STATUS_TIMER_BIT = 8;

  localparam logic [1:0] WR_BYTE = 2'b00;
  localparam logic [1:0] WR_HALF = 2'b01;
  localparam logic [1:0] WR_WORD = 2'b10;
  localparam logic [1:0] WR_NONE = 2'b11;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Byte lanes touched by a bus write of the given size.
  function automatic logic [31:0] lane_mask(input logic [1:0] size);
    case (size)
      WR_BYTE: lane_mask = 32'h0000_00FF;
      WR_HALF: lane_mask = 32'h0000_FFFF;
      WR_WORD: lane_mask = 32'hFFFF_FFFF;
      default: lane_mask = 32'h0000_0000;
    endcase
  endfunction

endpackage

// File: rtl/tqvp_input_filter.sv
// One-bit glitch filter with edge detection: the filtered value follows the
// input only after FILTER_CYC consecutive differing cycles.
module tqvp_input_filter
  import tqvp_gpio_irq_pkg::*;
#(
  parameter int FILTER_CYC = 3
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_in,
  input  logic [1:0] i_mode,
  output logic       o_filt,
  output logic       o_event
);

  logic r_filt;
  logic w_diff;
  logic w_upd;

  assign w_diff = i_in ^ r_filt;

  generate
    if (FILTER_CYC <= 1) begin : g_bypass
      assign w_upd = w_diff;
    end else begin : g_cnt
      localparam int CNT_W = $clog2(FILTER_CYC);
      logic [CNT_W-1:0] r_cnt;

      assign w_upd = w_diff && (r_cnt == CNT_W'(FILTER_CYC - 1));

      always_ff @(posedge i_clk) begin
        if (!i_rst_n || !w_diff || w_upd) r_cnt <= '0;
        else                              r_cnt <= r_cnt + 1'b1;
      end
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (!i_rst_n)   r_filt <= 1'b0;
    else if (w_upd) r_filt <= i_in;
  end

  // The event fires in the cycle the filtered value is about to toggle.
  assign o_event = w_upd &&
                   (( i_in && (i_mode == EDGE_RISE || i_mode == EDGE_BOTH)) ||
                    (!i_in && (i_mode == EDGE_FALL || i_mode == EDGE_BOTH)));
  assign o_filt  = r_filt;

endmodule

// File: rtl/tqvp_gpio_irq.sv
// TinyQV GPIO peripheral: output register, filtered edge interrupts and an
// auto-reload timer interrupt behind a W1C status / enable mask.
module tqvp_gpio_irq
  import tqvp_gpio_irq_pkg::*;
#(
  parameter int N_IN       = 8,
  parameter int FILTER_CYC = 3,
  parameter int TIMER_W    = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  localparam logic [8:0]  STATUS_MASK = 9'h100 | 9'((1 << N_IN) - 1);
  localparam logic [15:0] CFG_MASK    = 16'((1 << (2 * N_IN)) - 1);

  logic [7:0]         r_out;
  logic [15:0]        r_edge_cfg;
  logic [8:0]         r_status;
  logic [8:0]         r_enable;
  logic [TIMER_W-1:0] r_count;
  logic [TIMER_W-1:0] r_cmp;
  logic               r_ctrl;

  logic [N_IN-1:0] w_filt;
  logic [N_IN-1:0] w_evt;
  logic [31:0]     w_mask;
  logic            w_wr;
  logic            w_wr_count;
  logic            w_tmr_hit;
  logic [8:0]      w_set;
  logic [8:0]      w_clr;
  logic            w_unused_bits;

  assign w_wr       = (data_write_n != WR_NONE);
  assign w_mask     = lane_mask(data_write_n);
  assign w_wr_count = w_wr && (address == ADDR_COUNT);
  assign w_unused_bits = &{1'b0, data_read_n, ui_in, data_in, w_mask};

  for (genvar i = 0; i < N_IN; i++) begin : g_in
    tqvp_input_filter #(.FILTER_CYC(FILTER_CYC)) u_filt (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_in    (ui_in[i]),
      .i_mode  (r_edge_cfg[2*i +: 2]),
      .o_filt  (w_filt[i]),
      .o_event (w_evt[i])
    );
  end

  // A bus write to COUNT suppresses both the increment and the compare event.
  assign w_tmr_hit = r_ctrl && !w_wr_count && (r_count == r_cmp);

  assign w_set = {w_tmr_hit, 8'(w_evt)};
  assign w_clr = (w_wr && address == ADDR_STATUS) ? (data_in[8:0] & w_mask[8:0]) : 9'd0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out      <= '0;
      r_edge_cfg <= '0;
      r_enable   <= '0;
      r_cmp      <= '0;
      r_ctrl     <= 1'b0;
    end else if (w_wr) begin
      case (address)
        ADDR_OUT:      r_out      <= (r_out & ~w_mask[7:0]) | (data_in[7:0] & w_mask[7:0]);
        ADDR_EDGE_CFG: r_edge_cfg <= ((r_edge_cfg & ~w_mask[15:0]) |
                                      (data_in[15:0] & w_mask[15:0])) & CFG_MASK;
        ADDR_ENABLE:   r_enable   <= ((r_enable & ~w_mask[8:0]) |
                                      (data_in[8:0] & w_mask[8:0])) & STATUS_MASK;
        ADDR_CMP:      r_cmp      <= (r_cmp & ~w_mask[TIMER_W-1:0]) |
                                     (data_in[TIMER_W-1:0] & w_mask[TIMER_W-1:0]);
        ADDR_CTRL:     r_ctrl     <= data_in[0];
        default: ;
      endcase
    end
  end

  // Set beats a simultaneous W1C of the same bit.
  always_ff @(posedge clk) begin
    if (!rst_n) r_status <= '0;
    else        r_status <= ((r_status & ~w_clr) | w_set) & STATUS_MASK;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)          r_count <= '0;
    else if (w_wr_count) r_count <= (r_count & ~w_mask[TIMER_W-1:0]) |
                                    (data_in[TIMER_W-1:0] & w_mask[TIMER_W-1:0]);
    else if (w_tmr_hit)  r_count <= '0;
    else if (r_ctrl)     r_count <= r_count + 1'b1;
  end

  always_comb begin
    data_out = 32'd0;
    case (address)
      ADDR_OUT:      data_out = 32'(r_out);
      ADDR_IN:       data_out = 32'(w_filt);
      ADDR_EDGE_CFG: data_out = 32'(r_edge_cfg);
      ADDR_STATUS:   data_out = 32'(r_status);
      ADDR_ENABLE:   data_out = 32'(r_enable);
      ADDR_COUNT:    data_out = 32'(r_count);
      ADDR_CMP:      data_out = 32'(r_cmp);
      ADDR_CTRL:     data_out = 32'(r_ctrl);
      default:       data_out = 32'd0;
    endcase
  end

  assign uo_out         = r_out;
  assign data_ready     = 1'b1;
  assign user_interrupt = |(r_status & r_enable);

endmodule

// File: tb/tb_tqvp_gpio_irq.sv
// Bench for tqvp_gpio_irq: a cycle model of the register rules checked every
// cycle, plus directed scenarios with hand-derived literal expectations.
module tb_tqvp_gpio_irq;

  localparam int FC = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  ui_in = 8'h00;
  logic [7:0]  uo_out;
  logic [5:0]  address = 6'h00;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic [1:0]  data_read_n = 2'b11;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  int n_pass = 0;
  int n_total = 0;
  bit chk_en = 1'b0;

  tqvp_gpio_irq #(.N_IN(8), .FILTER_CYC(FC), .TIMER_W(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .ui_in          (ui_in),
    .uo_out         (uo_out),
    .address        (address),
    .data_in        (data_in),
    .data_write_n   (data_write_n),
    .data_read_n    (data_read_n),
    .data_out       (data_out),
    .data_ready     (data_ready),
    .user_interrupt (user_interrupt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model state
  bit [7:0]  m_out;
  bit [7:0]  m_filt;
  int        m_run [8];
  bit [15:0] m_edge;
  bit [8:0]  m_status;
  bit [8:0]  m_enable;
  bit [15:0] m_count;
  bit [15:0] m_cmp;
  bit        m_ctrl;

  function automatic bit [31:0] model_rd(input logic [5:0] a);
    case (a)
      6'h00: return {24'h0, m_out};
      6'h04: return {24'h0, m_filt};
      6'h08: return {16'h0, m_edge};
      6'h0C: return {23'h0, m_status};
      6'h10: return {23'h0, m_enable};
      6'h14: return {16'h0, m_count};
      6'h18: return {16'h0, m_cmp};
      6'h1C: return {31'h0, m_ctrl};
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin : model_p
    bit [31:0] mask, wd;
    bit        wr;
    bit [8:0]  set, clr;
    bit [7:0]  nf;
    bit [1:0]  mode;
    bit [15:0] nc;
    int        need;
    if (!rst_n) begin
      m_out <= '0; m_filt <= '0; m_edge <= '0; m_status <= '0;
      m_enable <= '0; m_count <= '0; m_cmp <= '0; m_ctrl <= 1'b0;
      for (int i = 0; i < 8; i++) m_run[i] <= 0;
    end else begin
      wr   = (data_write_n != 2'b11);
      mask = (data_write_n == 2'b00) ? 32'hFF : (data_write_n == 2'b01) ? 32'hFFFF : 32'hFFFF_FFFF;
      wd   = data_in & mask;
      set  = '0;
      clr  = '0;
      nf   = m_filt;
      need = (FC == 0) ? 1 : FC;
      for (int i = 0; i < 8; i++) begin
        if (ui_in[i] != m_filt[i]) begin
          if (m_run[i] + 1 >= need) begin
            nf[i] = ui_in[i];
            mode  = m_edge[2*i +: 2];
            if ((ui_in[i] && mode[0]) || (!ui_in[i] && mode[1])) set[i] = 1'b1;
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
      nc = m_count;
      if (wr && address == 6'h14) nc = (m_count & ~mask[15:0]) | wd[15:0];
      else if (m_ctrl) begin
        if (m_count == m_cmp) begin nc = 16'h0; set[8] = 1'b1; end
        else nc = m_count + 16'h1;
      end
      if (wr && address == 6'h0C) clr = wd[8:0];
      m_status <= (m_status & ~clr) | set;
      m_filt   <= nf;
      m_count  <= nc;
      if (wr) begin
        case (address)
          6'h00: m_out    <= (m_out & ~mask[7:0]) | wd[7:0];
          6'h08: m_edge   <= (m_edge & ~mask[15:0]) | wd[15:0];
          6'h10: m_enable <= (m_enable & ~mask[8:0]) | wd[8:0];
          6'h18: m_cmp    <= (m_cmp & ~mask[15:0]) | wd[15:0];
          6'h1C: m_ctrl   <= wd[0];
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("uo_out", {24'h0, uo_out}, {24'h0, m_out});
      check("user_interrupt", {31'h0, user_interrupt}, {31'h0, |(m_status & m_enable)});
      check("data_ready", {31'h0, data_ready}, 32'h1);
      check("data_out", data_out, model_rd(address));
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] sz);
    address = a;
    data_in = d;
    data_write_n = sz;
    tick(1);
    data_write_n = 2'b11;
  endtask

  task automatic rd_check(input string name, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    data_read_n = 2'b10;
    #1;
    check(name, data_out, exp);
    data_read_n = 2'b11;
  endtask

  logic [31:0] cnt_seq [6];

  initial begin
    cnt_seq = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd0};

    // Reset
    tick(2);
    chk_en = 1'b1;
    check("rst_uo_out", {24'h0, uo_out}, 32'h0);
    check("rst_irq", {31'h0, user_interrupt}, 32'h0);
    check("rst_ready", {31'h0, data_ready}, 32'h1);
    rd_check("rst_status", 6'h0C, 32'h0);
    rst_n = 1'b1;
    tick(1);

    // Basic register access
    wr(6'h00, 32'h5A, 2'b10);
    wr(6'h10, 32'hFF, 2'b00);
    check("out_5a", {24'h0, uo_out}, 32'h5A);
    rd_check("enable_ff", 6'h10, 32'hFF);
    rd_check("in_zero", 6'h04, 32'h0);

    // Glitch filter on input 0, rising edge
    wr(6'h08, 32'h0001, 2'b01);
    wr(6'h10, 32'h1, 2'b10);
    ui_in = 8'h01; tick(2);
    ui_in = 8'h00; tick(2);
    rd_check("pulse2_status", 6'h0C, 32'h0);
    rd_check("pulse2_in", 6'h04, 32'h0);
    ui_in = 8'h01; tick(2);
    rd_check("held2_in", 6'h04, 32'h0);
    tick(1);
    rd_check("held3_in", 6'h04, 32'h1);
    rd_check("held3_status", 6'h0C, 32'h1);
    check("held3_irq", {31'h0, user_interrupt}, 32'h1);

    // Input 1 in mode 11 (both edges)
    wr(6'h0C, 32'h1, 2'b10);
    rd_check("w1c_bit0", 6'h0C, 32'h0);
    wr(6'h08, 32'h000C, 2'b01);
    wr(6'h10, 32'h2, 2'b00);
    ui_in = 8'h03; tick(3);
    rd_check("in1_rise_status", 6'h0C, 32'h2);
    wr(6'h0C, 32'h2, 2'b00);
    check("in1_clr_irq", {31'h0, user_interrupt}, 32'h0);
    ui_in = 8'h01; tick(2);
    rd_check("in1_fall_pending", 6'h0C, 32'h0);
    tick(1);
    rd_check("in1_fall_status", 6'h0C, 32'h2);
    check("in1_fall_irq", {31'h0, user_interrupt}, 32'h1);
    wr(6'h0C, 32'h2, 2'b00);
    rd_check("in1_w1c", 6'h0C, 32'h0);
    check("in1_w1c_irq", {31'h0, user_interrupt}, 32'h0);

    // Auto-reload timer
    wr(6'h18, 32'h4, 2'b10);
    wr(6'h10, 32'h100, 2'b10);
    wr(6'h1C, 32'h1, 2'b00);
    for (int k = 0; k < 6; k++) begin
      rd_check("count_seq", 6'h14, cnt_seq[k]);
      if (k < 5) tick(1);
    end
    rd_check("timer_status", 6'h0C, 32'h100);
    check("timer_irq", {31'h0, user_interrupt}, 32'h1);
    wr(6'h0C, 32'h100, 2'b10);
    rd_check("timer_w1c", 6'h0C, 32'h0);
    tick(3);
    rd_check("count_at_4", 6'h14, 32'h4);
    wr(6'h0C, 32'h100, 2'b01);
    rd_check("set_beats_w1c", 6'h0C, 32'h100);
    rd_check("reload_count", 6'h14, 32'h0);
    wr(6'h0C, 32'h100, 2'b10);
    tick(3);
    wr(6'h14, 32'h10, 2'b10);
    rd_check("bus_beats_reload", 6'h14, 32'h10);
    rd_check("no_event_on_write", 6'h0C, 32'h0);
    tick(1);
    rd_check("count_after_write", 6'h14, 32'h11);
    wr(6'h1C, 32'h0, 2'b00);

    // Lane handling and unmapped space
    wr(6'h08, 32'hFFFF, 2'b00);
    rd_check("edge_byte_lane", 6'h08, 32'h00FF);
    wr(6'h00, 32'hAB12, 2'b01);
    check("out_half", {24'h0, uo_out}, 32'h12);
    wr(6'h10, 32'h1FF, 2'b00);
    rd_check("enable_byte_keeps_b8", 6'h10, 32'h1FF);
    wr(6'h04, 32'hFF, 2'b10);
    rd_check("in_readonly", 6'h04, 32'h1);
    rd_check("unmapped", 6'h20, 32'h0);

    // Reset in the middle of filtering
    ui_in = 8'h0F; tick(2);
    rst_n = 1'b0; tick(1);
    check("midrst_out", {24'h0, uo_out}, 32'h0);
    check("midrst_irq", {31'h0, user_interrupt}, 32'h0);
    rd_check("midrst_in", 6'h04, 32'h0);
    rd_check("midrst_cfg", 6'h08, 32'h0);
    rd_check("midrst_enable", 6'h10, 32'h0);
    rd_check("midrst_count", 6'h14, 32'h0);
    rst_n = 1'b1; tick(1);
    rd_check("postrst_in_1", 6'h04, 32'h0);
    tick(2);
    rd_check("postrst_in_3", 6'h04, 32'h0F);
    rd_check("postrst_status", 6'h0C, 32'h0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
